// File: rtl/mem_noc_sram_slave_pkg.sv
// Shared types and sizing for the mem_noc SRAM slave endpoint.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: MEM_ADDR_W/MEM_DATA_W bus sizing, byte-offset width, request/response structs.
package mem_noc_sram_slave_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_STRB_W = MEM_DATA_W / 8;
  // Number of byte-offset bits below a word address.
  localparam int BYTE_OFF_W = $clog2(MEM_STRB_W);

  typedef struct packed {
    logic [MEM_ADDR_W-1:0] addr;
    logic                  wen;
    logic [MEM_STRB_W-1:0] wmask;
    logic [MEM_DATA_W-1:0] wdata;
  } mem_req_t;

  typedef struct packed {
    logic [MEM_DATA_W-1:0] rdata;
  } mem_resp_t;

endpackage

// File: rtl/mem_noc_resp_fifo.sv
// First-word-fall-through FIFO with occupancy count, reusable by mem_noc endpoints.
// Latency: push at edge N is visible on pop_dat/!empty in the cycle after edge N.
// Backpressure: push while full is ignored; pop while empty is ignored.
// Ports: clk, rst (async active-high), push/push_dat, pop/pop_dat (head), count, empty.
module mem_noc_resp_fifo
  import mem_noc_sram_slave_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = mem_resp_t,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  T              push_dat,
  input  logic          pop,
  output T              pop_dat,
  output logic [CW-1:0] count,
  output logic          empty
);

  T              mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full;
  logic          push_ok;
  logic          pop_ok;

  // Pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Storage needs no reset: entries are only observed once written.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/mem_noc_sram_slave.sv
// Responder for one mem_noc slave port: decodes a window onto a 1-cycle synchronous SRAM.
// Latency: request accepted at edge t -> response valid in cycle t+1 (fall-through when idle).
// Backpressure: registered credit; req_ready drops once RESP_DEPTH responses are outstanding.
// Ports: clk, rst, base_addr, req_valid/req_ready/req, resp_valid/resp_ready/resp,
//        sram_ce/we/wmask/addr/wdata, sram_rdata, err_sticky.
module mem_noc_sram_slave
  import mem_noc_sram_slave_pkg::*;
#(
  parameter int WORD_AW    = 12,
  parameter int RESP_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [MEM_ADDR_W-1:0] base_addr,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  mem_req_t              req,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output mem_resp_t             resp,
  output logic                  sram_ce,
  output logic                  sram_we,
  output logic [MEM_STRB_W-1:0] sram_wmask,
  output logic [WORD_AW-1:0]    sram_addr,
  output logic [MEM_DATA_W-1:0] sram_wdata,
  input  logic [MEM_DATA_W-1:0] sram_rdata,
  output logic                  err_sticky
);

  localparam int CW      = $clog2(RESP_DEPTH + 1);
  localparam int WIN_LSB = WORD_AW + BYTE_OFF_W;

  logic [MEM_ADDR_W-1:0] off;
  logic                  in_window;
  logic                  accept;
  logic                  ready_q;
  logic                  s1_valid;
  logic                  s1_is_rd;
  logic                  s1_oow;
  mem_resp_t             s1_resp;
  mem_resp_t             fifo_dat;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_empty;
  logic [CW-1:0]         fifo_count;
  logic [CW:0]           occ_next;
  logic                  byte_off_unused;

  // Offset is taken modulo 2**MEM_ADDR_W, so a window may straddle address wrap.
  assign off             = req.addr - base_addr;
  assign in_window       = (off[MEM_ADDR_W-1:WIN_LSB] == '0);
  assign byte_off_unused = ^off[BYTE_OFF_W-1:0];

  assign req_ready = ready_q;
  assign accept    = req_valid && ready_q;

  // SRAM strobes are gated by the access so idle and out-of-window cycles drive zeros.
  assign sram_ce    = accept && in_window;
  assign sram_we    = sram_ce && req.wen;
  assign sram_wmask = sram_ce ? req.wmask : '0;
  assign sram_addr  = sram_ce ? off[WIN_LSB-1:BYTE_OFF_W] : '0;
  assign sram_wdata = sram_ce ? req.wdata : '0;

  // Stage-1 response: SRAM read data lands here one cycle after the access.
  assign s1_resp.rdata = (s1_is_rd && !s1_oow) ? sram_rdata : '0;

  // FIFO head has priority; s1 bypasses only when nothing older is queued.
  assign fifo_pop  = !fifo_empty && resp_ready;
  assign fifo_push = s1_valid && !(fifo_empty && resp_ready);

  always_comb begin
    resp_valid = 1'b0;
    resp       = '0;
    if (!fifo_empty) begin
      resp_valid = 1'b1;
      resp       = fifo_dat;
    end else if (s1_valid) begin
      resp_valid = 1'b1;
      resp       = s1_resp;
    end
  end

  // Outstanding responses after this edge: queued entries plus the request entering s1.
  assign occ_next = (CW+1)'(fifo_count) + (CW+1)'(fifo_push) - (CW+1)'(fifo_pop)
                  + (CW+1)'(accept);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q    <= 1'b0;
      s1_valid   <= 1'b0;
      s1_is_rd   <= 1'b0;
      s1_oow     <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      ready_q  <= (occ_next < (CW+1)'(RESP_DEPTH));
      s1_valid <= accept;
      s1_is_rd <= !req.wen;
      s1_oow   <= !in_window;
      if (accept && !in_window) err_sticky <= 1'b1;
    end
  end

  mem_noc_resp_fifo #(
    .DEPTH (RESP_DEPTH),
    .T     (mem_resp_t)
  ) u_resp_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_dat (s1_resp),
    .pop      (fifo_pop),
    .pop_dat  (fifo_dat),
    .count    (fifo_count),
    .empty    (fifo_empty)
  );

  // Credit must keep the FIFO from ever seeing a push while full.
  a_credit: assert property (@(posedge clk) disable iff (rst)
    ((CW+1)'(fifo_count) + (CW+1)'(s1_valid)) <= (CW+1)'(RESP_DEPTH));

endmodule
